// File: rtl/irq_sense_pend_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_sense_pend_if
// Brief    : Interrupt request, mask, sense-mode and pending bundle for the
//            PLIC sensing stage.
// Revision : 1.0  initial release
// ============================================================================
interface irq_sense_pend_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0]   irq_in;
    logic [NUM_IRQ-1:0]   irq_enable;
    logic [2*NUM_IRQ-1:0] irq_sense;
    logic [NUM_IRQ-1:0]   pend_clr;
    logic [NUM_IRQ-1:0]   irq_pending;
    logic [NUM_IRQ-1:0]   irq_req;
    logic                 irq_any;

    modport master (
        output irq_in, irq_enable, irq_sense, pend_clr,
        input  irq_pending, irq_req, irq_any
    );

    modport slave (
        input  irq_in, irq_enable, irq_sense, pend_clr,
        output irq_pending, irq_req, irq_any
    );
endinterface
`default_nettype wire

// File: rtl/irq_sense_pend.sv
`default_nettype none
// ============================================================================
// Module   : irq_sense_pend
// Brief    : Per-channel synchroniser, edge/level detect and pending latch
//            with enable masking. Optional glitch filter: IRQ_SENSE_FILTER_EN.
// Revision : 1.0  initial release
// ============================================================================
module irq_sense_pend #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        pclk,
    input  wire logic        preset_n,
    irq_sense_pend_if.slave  bus
);

    localparam logic [1:0] c_MODE_LEVEL = 2'b00;
    localparam logic [1:0] c_MODE_FALL  = 2'b01;
    localparam logic [1:0] c_MODE_RISE  = 2'b10;
    localparam logic [1:0] c_MODE_BOTH  = 2'b11;

    logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_s;
    logic [NUM_IRQ-1:0] w_fall;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_both;
    logic [NUM_IRQ-1:0] w_low;
    logic [NUM_IRQ-1:0] w_pend_nxt;

    // Idle-high reset so the first real sample after reset cannot look like a fall.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '1;
            end
        end else begin
            r_sync[0] <= bus.irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef IRQ_SENSE_FILTER_EN
    logic [NUM_IRQ-1:0] r_flt_last;
    logic [NUM_IRQ-1:0] w_agree;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_flt_last <= '1;
        end else begin
            r_flt_last <= w_sync;
        end
    end

    // r_prev always holds the previous filtered value, so it doubles as the filter's hold state.
    assign w_agree = ~(w_sync ^ r_flt_last);
    assign w_s     = (w_agree & w_sync) | (~w_agree & r_prev);
`else
    assign w_s = w_sync;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_prev <= '1;
        end else begin
            r_prev <= w_s;
        end
    end

    assign w_fall = r_prev & ~w_s;
    assign w_rise = ~r_prev & w_s;
    assign w_both = r_prev ^ w_s;
    assign w_low  = ~w_s;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
            logic [1:0] w_mode;
            logic       w_set;

            assign w_mode = bus.irq_sense[2*gi +: 2];

            always_comb begin
                w_set = 1'b0;
                case (w_mode)
                    c_MODE_FALL: w_set = w_fall[gi];
                    c_MODE_RISE: w_set = w_rise[gi];
                    c_MODE_BOTH: w_set = w_both[gi];
                    default:     w_set = 1'b0;
                endcase
            end

            // A set on the same edge as a clear wins.
            assign w_pend_nxt[gi] = (w_mode == c_MODE_LEVEL) ? w_low[gi]
                                  : (w_set | (r_pending[gi] & ~bus.pend_clr[gi]));
        end
    endgenerate

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_nxt;
        end
    end

    assign bus.irq_pending = r_pending;
    assign bus.irq_req     = r_pending & bus.irq_enable;
    assign bus.irq_any     = |(r_pending & bus.irq_enable);

endmodule
`default_nettype wire

// File: doc/irq_sense_pend.md
# irq_sense_pend

Parametrised interrupt sensing and pending stage for the PLIC. It synchronises NUM_IRQ asynchronous request lines and detects level-low, falling, rising or both-edge events per channel. Edge events are held in a pending register until software clears them. Enable masks are applied to produce the per-channel requests consumed by the PLIC priority/arbitration logic.

## Interface
Parameters:
- NUM_IRQ, 8, number of interrupt channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (>= 2)

Ports:
- pclk  input  1  clock
- preset_n  input  1  reset, asynchronous, active-low
- irq_in  input  NUM_IRQ  raw asynchronous interrupt lines, bit i = channel i
- irq_enable  input  NUM_IRQ  per-channel request mask, 1 = enabled
- irq_sense  input  2*NUM_IRQ  mode of channel i in bits [2i+1:2i]: 00 level-low, 01 falling, 10 rising, 11 both edges
- pend_clr  input  NUM_IRQ  write-one-to-clear pulse per channel, from the register interface
- irq_pending  output  NUM_IRQ  registered pending status, not masked
- irq_req  output  NUM_IRQ  irq_pending & irq_enable
- irq_any  output  1  OR-reduction of irq_req

## Operation
- Per channel, the datapath is a synchroniser chain, then a previous-sample register, then a pending flop.
- Synchroniser flops and the previous-sample register reset to 1 (idle-high), so no false falling edge occurs after reset.
- Event terms from synced value s and previous value p:
  - fall = p & ~s
  - rise = ~p & s
  - both = p ^ s
  - low = ~s
- Edge modes (01/10/11):
  - The pending flop sets on the selected event and holds until pend_clr[i].
  - Set wins over a simultaneous pend_clr[i]: the pending bit stays 1.
  - Further edges while pending are absorbed; there is no counting.
- Level mode (00):
  - The pending flop loads ~s every cycle.
  - pend_clr[i] has no lasting effect; the bit reasserts next cycle if the line is still low.
- irq_enable gates only irq_req. Pending bits are set and held while the channel is masked. Enabling a channel with pending = 1 raises irq_req combinationally.
- Changing irq_sense[i] never clears pending directly.
  - Edge to level: the bit follows ~s from the next cycle.
  - Level to edge: the bit holds its current value until cleared or set.
- Channels are fully independent; no priority is applied here.

## Timing
- Reset values:
  - irq_pending = 0, irq_req = 0, irq_any = 0.
  - Synchroniser and previous-sample flops = 1.
- Latency: an input transition captured by sync stage 0 at edge E0 appears on irq_pending after edge E(SYNC_STAGES). This is 3 cycles for the default (2 sync stages plus pending flop); add 1 cycle with the filter macro.
- irq_req and irq_any are combinational from irq_pending and irq_enable: same cycle, no extra latency.
- pend_clr asserted during the cycle before edge Ek clears the bit at Ek, provided no set occurs at Ek.
- Pulses on irq_in shorter than one pclk period may be missed. This is not required to be detected.
- Reset asserted mid-operation clears all pending bits immediately (asynchronous). There is no spurious edge event on release.

## Configuration
- Macro: IRQ_SENSE_FILTER_EN.
- Defined:
  - A 2-sample glitch filter follows the synchroniser. The filtered value s changes only when the last two synced samples agree and differ from s.
  - Single-cycle pulses are rejected.
  - Latency becomes SYNC_STAGES+2 edges.
  - Filter registers reset to 1.
- Undefined: s is the last synchroniser stage directly; there is no filter logic.

## Test plan
Bench uses NUM_IRQ=8, SYNC_STAGES=2 unless noted.
- Reset, all irq_in=1, irq_sense=16'h0000 -> all outputs 0 during and after reset; irq_pending stays 8'h00 for 10 cycles.
- Channel 2 rising (irq_sense[5:4]=10), irq_enable=8'h04, irq_in[2] 0->1 captured at E0:
  - irq_pending=8'h04 and irq_any=1 after E2.
  - Remains set after irq_in[2] returns to 0.
  - pend_clr=8'h04 for one cycle clears it.
- Channel 5 falling, irq_enable[5]=0, falling edge -> irq_pending[5]=1 and irq_req[5]=0; raising irq_enable[5] gives irq_req=8'h20 in the same cycle.
- Channel 0 level-low, hold irq_in[0]=0 for 5 cycles with pend_clr[0] pulsed -> irq_pending[0] drops at most one cycle, then reasserts; it goes 0 three edges after irq_in[0] returns to 1.
- Channel 7 both-edge, pend_clr[7] asserted in the same cycle as a detected edge -> irq_pending[7] remains 1 (set wins).
- With IRQ_SENSE_FILTER_EN, channel 1 rising:
  - A one-cycle high pulse leaves irq_pending=8'h00.
  - A three-cycle high pulse sets irq_pending[1] after E3.
